// File: rtl/alu_result_tx_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the ALU result
// to UART byte transmitter.
package alu_tx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_result_tx_ctrl_fifo.sv
// Result FIFO between the ALU and the byte sender; extra pointer
// MSB tells full from empty.
module result_fifo
  import alu_tx_pkg::*;
#(
  parameter int Width = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [Width-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop) rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full = (wptr[AW] != rptr[AW]) &&
                (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/alu_result_tx_ctrl.sv
// Queues ALU results and feeds them bytewise to the UART TX.
// Define ALU_TX_MSB_FIRST_EN to send the most-significant byte first.
module alu_result_tx_ctrl
  import alu_tx_pkg::*;
#(
  parameter int Width = 16,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] ALU_OUT,
  input  logic             OUT_VALID,
  input  logic             TX_BUSY,
  output logic [7:0]       TX_P_DATA,
  output logic             TX_D_VALID,
  output logic             OVERRUN,
  output logic             IDLE
);

  localparam int NB = Width / BYTE_W;
  localparam int CW = (NB > 1) ? clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);
  localparam logic [CW-1:0] ONE = 1;

  state_t           state;
  logic [Width-1:0] shreg;
  logic [Width-1:0] nxt;
  logic [Width-1:0] head;
  logic [7:0]       cur;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;

  // A pop in the same cycle frees the slot the push lands in.
  assign pop = (state == S_LOAD);
  assign push = OUT_VALID && (!full || pop);

  result_fifo #(
    .Width(Width),
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .push (push),
    .pop  (pop),
    .wdata(ALU_OUT),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

`ifdef ALU_TX_MSB_FIRST_EN
  assign cur = shreg[Width-1 -: BYTE_W];
  assign nxt = shreg << BYTE_W;
`else
  assign cur = shreg[BYTE_W-1:0];
  assign nxt = shreg >> BYTE_W;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      TX_P_DATA  <= '0;
      TX_D_VALID <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      TX_D_VALID <= 1'b0;
      if (OUT_VALID && full && !pop) OVERRUN <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (!empty) state <= S_LOAD;
        end
        S_LOAD: begin
          shreg <= head;
          cnt   <= LAST;
          state <= S_SEND;
        end
        S_SEND: begin
          if (!TX_BUSY) begin
            TX_P_DATA  <= cur;
            TX_D_VALID <= 1'b1;
            state      <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (TX_BUSY) state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (!TX_BUSY) begin
            if (cnt == '0) begin
              state <= empty ? S_IDLE : S_LOAD;
            end else begin
              shreg <= nxt;
              cnt   <= cnt - ONE;
              state <= S_SEND;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign IDLE = empty && (state == S_IDLE);

endmodule

// File: tb/tb_alu_result_tx_ctrl.sv
// Bench for alu_result_tx_ctrl: UART busy model, byte scoreboard,
// directed corner cases and randomised bursts.
`timescale 1ns/1ps
module tb_alu_result_tx_ctrl;

  localparam int W = 16;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] ALU_OUT = '0;
  logic         OUT_VALID = 1'b0;
  logic         TX_BUSY = 1'b0;
  logic [7:0]   TX_P_DATA;
  logic         TX_D_VALID;
  logic         OVERRUN;
  logic         IDLE;

  int tests = 0;
  int fails = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  int dly = 1;
  int hl = 10;
  int pend = 0;
  int hold = 0;
  int falls = 0;
  bit force_busy = 1'b0;
  bit forced = 1'b0;
  bit prev_v = 1'b0;

  always #5 CLK = ~CLK;

  alu_result_tx_ctrl #(
    .Width(W),
    .DEPTH(D)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .TX_BUSY   (TX_BUSY),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VALID(TX_D_VALID),
    .OVERRUN   (OVERRUN),
    .IDLE      (IDLE)
  );

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // UART: busy rises dly cycles after a strobe, stays high hl cycles
  initial forever begin
    @(negedge CLK);
    if (!RST) begin
      TX_BUSY = 1'b0;
      pend = 0;
      hold = 0;
      forced = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (TX_D_VALID) begin
        check("dv_while_busy", 32'(TX_BUSY), 0);
        check("dv_back_to_back", 32'(prev_v), 0);
        got_q.push_back(TX_P_DATA);
      end
      prev_v = TX_D_VALID;
      if (force_busy) begin
        TX_BUSY = 1'b1;
        forced = 1'b1;
      end else if (forced) begin
        TX_BUSY = 1'b0;
        forced = 1'b0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          TX_BUSY = 1'b0;
          falls++;
        end
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          TX_BUSY = 1'b1;
          hold = hl;
        end
      end
      if (TX_D_VALID) pend = dly;
    end
  end

  function automatic void add_exp(logic [W-1:0] v);
    for (int i = 0; i < W / 8; i++) begin
`ifdef ALU_TX_MSB_FIRST_EN
      exp_q.push_back(8'(v >> (8 * (W / 8 - 1 - i))));
`else
      exp_q.push_back(8'(v >> (8 * i)));
`endif
    end
  endfunction

  task automatic compare_q(string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    OUT_VALID = 1'b0;
    force_busy = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    got_q.delete();
    exp_q.delete();
    dly = 1;
    hl = 10;
    @(negedge CLK);
  endtask

  task automatic push(logic [W-1:0] v);
    ALU_OUT = v;
    OUT_VALID = 1'b1;
    @(negedge CLK);
    OUT_VALID = 1'b0;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    repeat (3) @(negedge CLK);
    while (!(IDLE && !TX_BUSY && pend == 0 && hold == 0) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_drain"}, 32'(n < 2000), 1);
  endtask

  initial begin
    int lat;
    int n;
    logic [W-1:0] v;

    @(negedge CLK);
    check("rst_data", 32'(TX_P_DATA), 0);
    check("rst_dv", 32'(TX_D_VALID), 0);
    check("rst_ovr", 32'(OVERRUN), 0);
    check("rst_idle", 32'(IDLE), 1);

    // single result and first-strobe latency
    do_reset();
    add_exp(16'hA55A);
    push(16'hA55A);
    lat = 0;
    while (!TX_D_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    check("latency", lat, 3);
    drain("single");
    compare_q("single");
    check("single_idle", 32'(IDLE), 1);

    // back-to-back pushes
    do_reset();
    push(16'h0102);
    push(16'h0304);
    push(16'h0506);
    add_exp(16'h0102);
    add_exp(16'h0304);
    add_exp(16'h0506);
    drain("b2b");
    compare_q("b2b");
    check("b2b_ovr", 32'(OVERRUN), 0);

    // overrun with the UART stalled
    do_reset();
    force_busy = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 1; i <= 6; i++) push(16'(i * 16'h0011));
    repeat (3) @(negedge CLK);
    check("ovr_set", 32'(OVERRUN), 1);
    check("ovr_not_idle", 32'(IDLE), 0);
    check("ovr_nothing_sent", got_q.size(), 0);
    for (int i = 1; i <= 5; i++) add_exp(16'(i * 16'h0011));
    force_busy = 1'b0;
    drain("ovr");
    compare_q("ovr");
    check("ovr_sticky", 32'(OVERRUN), 1);

    // push into a full FIFO on the cycle the FSM pops
    do_reset();
    force_busy = 1'b1;
    repeat (2) @(negedge CLK);
    for (int i = 1; i <= 5; i++) begin
      push(16'h1000 + 16'(i));
      add_exp(16'h1000 + 16'(i));
    end
    falls = 0;
    force_busy = 1'b0;
    n = 0;
    while (falls < 2 && n < 200) begin
      @(posedge CLK);
      n++;
    end
    check("fwp_wait", 32'(falls >= 2), 1);
    @(negedge CLK);
    push(16'h2222);
    add_exp(16'h2222);
    drain("fwp");
    compare_q("fwp");
    check("fwp_ovr", 32'(OVERRUN), 0);

    // reset while waiting for the first byte to finish
    do_reset();
    push(16'hBEEF);
    n = 0;
    while (got_q.size() == 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    check("mid_rst_data", 32'(TX_P_DATA), 0);
    check("mid_rst_dv", 32'(TX_D_VALID), 0);
    check("mid_rst_ovr", 32'(OVERRUN), 0);
    check("mid_rst_idle", 32'(IDLE), 1);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (40) @(negedge CLK);
    add_exp(16'hBEEF);
    void'(exp_q.pop_back());
    compare_q("mid_rst");
    check("mid_rst_idle_after", 32'(IDLE), 1);

    // randomised bursts that never exceed FIFO plus shift register
    do_reset();
    for (int r = 0; r < 8; r++) begin
      dly = $urandom_range(1, 3);
      hl = $urandom_range(1, 12);
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        v = W'($urandom_range(0, 16'hFFFF));
        add_exp(v);
        push(v);
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
      drain("rnd");
      compare_q("rnd");
      check("rnd_ovr", 32'(OVERRUN), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
